// File: rtl/ifu_iexec_issue_if.sv
// Fetch-side and iexec-side handshake bundle for the instruction issue buffer.
// The issue buffer is the master of the iexec request and the sink of fetch.
interface ifu_iexec_issue_if;
  logic        fetch_vld;
  logic        fetch_rdy;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_ir;
  logic        iexec_req_vld;
  logic        iexec_req_rdy;
  logic [31:0] iexec_req_pc;
  logic [31:0] iexec_req_ir;
  logic        opc_lui;
  logic        opc_auipc;
  logic        opc_alu_imm;
  logic        opc_ill;

  modport master (
    input  fetch_vld, fetch_pc, fetch_ir, iexec_req_rdy,
    output fetch_rdy, iexec_req_vld, iexec_req_pc, iexec_req_ir,
           opc_lui, opc_auipc, opc_alu_imm, opc_ill
  );

  modport slave (
    output fetch_vld, fetch_pc, fetch_ir, iexec_req_rdy,
    input  fetch_rdy, iexec_req_vld, iexec_req_pc, iexec_req_ir,
           opc_lui, opc_auipc, opc_alu_imm, opc_ill
  );
endinterface

// File: rtl/ifu_iexec_issue.sv
// Instruction issue buffer: small FIFO of {pc, ir, predecoded opcode class}
// presenting the head entry to the EXU as a valid/ready request.
module ifu_iexec_issue #(
  parameter int          DEPTH  = 2,
  parameter logic [31:0] PC_RST = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ifu_iexec_issue_if.master          bus,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ir_mem  [DEPTH];
  logic [3:0]    opc_mem [DEPTH];
  logic          empty, full, enq, deq;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [3:0]    head_opc;

  // Opcode class bits: [0] lui, [1] auipc, [2] alu_imm, [3] illegal.
  function automatic logic [3:0] decode_opc(input logic [31:0] ir);
    logic [3:0] o;
    o = '0;
    if (ir[1:0] != 2'b11) begin
      o[3] = 1'b1;
    end else begin
      case (ir[6:0])
        7'b0110111: o[0] = 1'b1;
        7'b0010111: o[1] = 1'b1;
        7'b0010011: o[2] = 1'b1;
        default:    o[3] = 1'b1;
      endcase
    end
    return o;
  endfunction

  assign wr_idx    = wr_ptr[AW-1:0];
  assign rd_idx    = rd_ptr[AW-1:0];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
  assign occupancy = wr_ptr - rd_ptr;

  // Ready is a function of state, flush and reset only; never of fetch_vld.
  assign bus.fetch_rdy = rst_n && !full && !flush;
  assign enq           = bus.fetch_vld && bus.fetch_rdy;
  assign bus.iexec_req_vld = !empty;
  assign deq           = bus.iexec_req_vld && bus.iexec_req_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is data only and intentionally left unreset.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_idx]  <= bus.fetch_pc;
      ir_mem[wr_idx]  <= bus.fetch_ir;
      opc_mem[wr_idx] <= decode_opc(bus.fetch_ir);
    end
  end

  assign head_opc         = empty ? 4'b0000 : opc_mem[rd_idx];
  assign bus.iexec_req_pc = empty ? PC_RST : pc_mem[rd_idx];
  assign bus.iexec_req_ir = empty ? 32'h0000_0013 : ir_mem[rd_idx];
  assign bus.opc_lui      = head_opc[0];
  assign bus.opc_auipc    = head_opc[1];
  assign bus.opc_alu_imm  = head_opc[2];
  assign bus.opc_ill      = head_opc[3];

  a_no_enq_full: assert property (@(posedge clk) disable iff (!rst_n) !(enq && full));
  a_no_deq_empty: assert property (@(posedge clk) disable iff (!rst_n) !(deq && empty));
  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n) occupancy <= PW'(DEPTH));
endmodule

// File: tb/tb_ifu_iexec_issue.sv
// Scoreboard bench for ifu_iexec_issue: directed vectors with hand-computed
// expected pc/ir/opcode class, checked by a monitor on every iexec handshake.
module tb_ifu_iexec_issue;
  localparam logic [31:0] PC_RST = 32'hDEAD_0000;
  localparam logic [3:0]  OPC_NONE = 4'b0000, OPC_LUI = 4'b0001, OPC_AUIPC = 4'b0010,
                          OPC_ALU = 4'b0100, OPC_ILL = 4'b1000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [3:0]  opc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] occupancy;
  logic [3:0] drv_opc = OPC_NONE;
  int         checks = 0;
  int         errors = 0;
  int         hsk_cnt = 0;
  exp_t       exp_q[$];

  ifu_iexec_issue_if bus ();

  ifu_iexec_issue #(.DEPTH(2), .PC_RST(PC_RST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .flush     (flush),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] head_opc();
    return {bus.opc_ill, bus.opc_alu_imm, bus.opc_auipc, bus.opc_lui};
  endfunction

  // Monitor: dequeue compare first, then enqueue push; flush/reset drop the model.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.iexec_req_vld && bus.iexec_req_rdy) begin
        hsk_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue act=pc %h exp=no issue", bus.iexec_req_pc);
        end else begin
          e = exp_q.pop_front();
          chk("issue_pc", bus.iexec_req_pc, e.pc);
          chk("issue_ir", bus.iexec_req_ir, e.ir);
          chk("issue_opc", 32'(head_opc()), 32'(e.opc));
        end
      end
      if (bus.fetch_vld && bus.fetch_rdy) exp_q.push_back('{bus.fetch_pc, bus.fetch_ir, drv_opc});
      if (flush) exp_q.delete();
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] ir, input logic [3:0] opc);
    bus.fetch_vld = 1'b1;
    bus.fetch_pc  = pc;
    bus.fetch_ir  = ir;
    drv_opc       = opc;
  endtask

  task automatic enq(input logic [31:0] pc, input logic [31:0] ir, input logic [3:0] opc);
    offer(pc, ir, opc);
    cycle();
    bus.fetch_vld = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    bus.iexec_req_rdy = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.iexec_req_vld) && n < 20) begin
      cycle();
      n++;
    end
    if (n >= 20) chk({name, "_drain_timeout"}, 32'(n), 32'd0);
    bus.iexec_req_rdy = 1'b0;
  endtask

  initial begin
    int base;
    bus.fetch_vld = 1'b0;
    bus.fetch_pc = '0;
    bus.fetch_ir = '0;
    bus.iexec_req_rdy = 1'b0;

    // Reset held from time zero.
    #12;
    chk("rst_fetch_rdy_low", 32'(bus.fetch_rdy), 32'd0);
    chk("rst_vld", 32'(bus.iexec_req_vld), 32'd0);
    cycle();
    rst_n = 1'b1;
    #1;
    chk("rel_fetch_rdy", 32'(bus.fetch_rdy), 32'd1);
    chk("rel_occ", 32'(occupancy), 32'd0);
    chk("rel_pc", bus.iexec_req_pc, PC_RST);
    chk("rel_ir", bus.iexec_req_ir, 32'h0000_0013);
    chk("rel_opc", 32'(head_opc()), 32'(OPC_NONE));

    // lui held through five stalled cycles.
    enq(32'h100, 32'h1234_5037, OPC_LUI);
    chk("lui_vld", 32'(bus.iexec_req_vld), 32'd1);
    chk("lui_opc", 32'(head_opc()), 32'(OPC_LUI));
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_vld", 32'(bus.iexec_req_vld), 32'd1);
      chk("stall_pc", bus.iexec_req_pc, 32'h100);
      chk("stall_ir", bus.iexec_req_ir, 32'h1234_5037);
      chk("stall_opc", 32'(head_opc()), 32'(OPC_LUI));
    end
    base = hsk_cnt;
    bus.iexec_req_rdy = 1'b1;
    cycle();
    bus.iexec_req_rdy = 1'b0;
    chk("lui_hsk", 32'(hsk_cnt - base), 32'd1);
    chk("lui_empty", 32'(bus.iexec_req_vld), 32'd0);

    // Fill, then offer and dequeue in the same full cycle.
    enq(32'h200, 32'h0000_0097, OPC_AUIPC);
    enq(32'h204, 32'h0010_0093, OPC_ALU);
    chk("full_rdy", 32'(bus.fetch_rdy), 32'd0);
    chk("full_occ", 32'(occupancy), 32'd2);
    offer(32'h208, 32'h0000_0037, OPC_LUI);
    bus.iexec_req_rdy = 1'b1;
    cycle();
    bus.fetch_vld = 1'b0;
    bus.iexec_req_rdy = 1'b0;
    chk("full_deq_rdy", 32'(bus.fetch_rdy), 32'd1);
    chk("full_deq_occ", 32'(occupancy), 32'd1);
    chk("full_head_pc", bus.iexec_req_pc, 32'h204);
    drain("fill");

    // Streaming across pointer wrap.
    base = hsk_cnt;
    bus.iexec_req_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      offer(32'h500 + 32'(4 * i), 32'h0000_0013 | (32'(i) << 20), OPC_ALU);
      cycle();
      chk("stream_occ", 32'(occupancy), 32'd1);
      chk("stream_vld", 32'(bus.iexec_req_vld), 32'd1);
    end
    bus.fetch_vld = 1'b0;
    cycle();
    bus.iexec_req_rdy = 1'b0;
    chk("stream_hsk", 32'(hsk_cnt - base), 32'd9);
    chk("stream_occ_end", 32'(occupancy), 32'd0);

    // Flush with two buffered entries and a concurrent fetch offer.
    enq(32'h300, 32'h0000_0017, OPC_AUIPC);
    enq(32'h304, 32'h0000_0017, OPC_AUIPC);
    offer(32'h308, 32'h0000_1037, OPC_LUI);
    flush = 1'b1;
    #1;
    chk("flush_rdy", 32'(bus.fetch_rdy), 32'd0);
    cycle();
    flush = 1'b0;
    bus.fetch_vld = 1'b0;
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_vld", 32'(bus.iexec_req_vld), 32'd0);
    base = hsk_cnt;
    bus.iexec_req_rdy = 1'b1;
    repeat (3) cycle();
    bus.iexec_req_rdy = 1'b0;
    chk("flush_no_issue", 32'(hsk_cnt - base), 32'd0);

    // Illegal encodings.
    enq(32'h400, 32'h0000_0033, OPC_ILL);
    chk("ill_rtype", 32'(head_opc()), 32'(OPC_ILL));
    drain("ill_a");
    enq(32'h404, 32'h0000_0000, OPC_ILL);
    chk("ill_zero", 32'(head_opc()), 32'(OPC_ILL));
    drain("ill_b");

    // Asynchronous reset mid-operation with two entries buffered.
    enq(32'h600, 32'h0000_0037, OPC_LUI);
    enq(32'h604, 32'h0000_0037, OPC_LUI);
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(bus.iexec_req_vld), 32'd0);
    chk("mid_rst_occ", 32'(occupancy), 32'd0);
    chk("mid_rst_pc", bus.iexec_req_pc, PC_RST);
    chk("mid_rst_rdy", 32'(bus.fetch_rdy), 32'd0);
    cycle();
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy", 32'(bus.fetch_rdy), 32'd1);
    chk("post_rst_vld", 32'(bus.iexec_req_vld), 32'd0);
    base = hsk_cnt;
    bus.iexec_req_rdy = 1'b1;
    repeat (2) cycle();
    bus.iexec_req_rdy = 1'b0;
    chk("post_rst_no_issue", 32'(hsk_cnt - base), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
